// File: rtl/fetch_unit_if.sv
// Fetch front-end bus bundle: instruction memory request/response,
// EX-stage redirect and the decode-side head instruction.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_plus_4;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, pc_plus_4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect, redirect_pc, id_ready
    );

    // Memory / pipeline environment side
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, pc_plus_4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues handshaked memory
// requests under a credit limit, buffers in-order responses in a prefetch
// queue and flushes stale work on EX redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] QDEPTH_W = (CW + 1)'(QDEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]   instr_mem_q [QDEPTH];
    logic [31:0]   pc4_mem_q   [QDEPTH];

    logic [CW:0]   inflight;
    logic [31:0]   redirect_target;
    logic          head_valid;
    logic          req_fire;
    logic          enq;
    logic          deq;

    // Credits cover both queued and in-flight words so the queue cannot overflow.
    assign inflight        = {1'b0, outstanding_q} + {1'b0, count_q};
    assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
    assign head_valid      = (count_q != '0);

    assign bus.imem_req_valid = reset && !bus.redirect && (inflight < QDEPTH_W);
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instr          = head_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign bus.pc_plus_4      = head_valid ? pc4_mem_q[rd_ptr_q]   : '0;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign enq      = bus.imem_rsp_valid && !bus.redirect && (drop_cnt_q == '0);
    assign deq      = head_valid && bus.id_ready && !bus.redirect;

    // Next-state logic; a redirect overrides every other event in its cycle.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (bus.redirect) begin
            fetch_pc_d    = redirect_target;
            rsp_pc_d      = redirect_target;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            // Whatever is still in flight after this cycle belongs to the old path.
            outstanding_d = outstanding_q - CW'(bus.imem_rsp_valid);
            drop_cnt_d    = outstanding_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Queue storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
            pc4_mem_q[wr_ptr_q]   <= rsp_pc_q + 32'd4;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order variable-latency memory model
// and a path-level reference model that expects decode to see consecutive
// words starting at the latest redirect target (or RESET_PC).
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 4;

    logic clk;
    logic reset;
    fetch_unit_if bus_if ();

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
        bit          stale;
    } ent_t;

    ent_t        pq[$];
    int          cyc;
    int          last_due;
    int          checks;
    int          errors;
    logic [31:0] exp_req_addr;
    logic [31:0] exp_deliv;
    int          issued;
    int          delivered;
    int          fresh_arr;
    int          p_idr, p_rdy, p_redir, lat_lo, lat_hi;

    function automatic logic [31:0] memf(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0:       t = $urandom;
            1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            2:       t = $urandom & 32'hFFFF_FFFC;
            default: t = 32'h0000_0100;
        endcase
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        last_due     = cyc;
        exp_req_addr = RESET_PC;
        exp_deliv    = RESET_PC;
        issued       = 0;
        delivered    = 0;
        fresh_arr    = 0;
    endtask

    task automatic drive_idle();
        bus_if.imem_req_ready = 1'b0;
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data  = '0;
        bus_if.redirect       = 1'b0;
        bus_if.redirect_pc    = '0;
        bus_if.id_ready       = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_req_valid",   32'(bus_if.imem_req_valid), 32'd0);
        check("rst_req_addr",    bus_if.imem_req_addr, RESET_PC);
        check("rst_instr_valid", 32'(bus_if.instr_valid), 32'd0);
        check("rst_instr",       bus_if.instr, 32'd0);
        check("rst_pc_plus_4",   bus_if.pc_plus_4, 32'd0);
    endtask

    // One clock cycle: drive at negedge, check settled outputs, then advance
    // the model by the events that the next rising edge will commit.
    task automatic cycle(input bit force_redir, input logic [31:0] force_pc);
        int   stale_n;
        int   held;
        int   due;
        bit   exp_rv;
        bit   exp_iv;
        ent_t e;
        @(negedge clk);
        cyc++;
        bus_if.id_ready       = (int'($urandom_range(99)) < p_idr);
        bus_if.imem_req_ready = (int'($urandom_range(99)) < p_rdy);
        bus_if.redirect       = force_redir || (int'($urandom_range(99)) < p_redir);
        bus_if.redirect_pc    = force_redir ? force_pc : rand_target();
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            bus_if.imem_rsp_valid = 1'b1;
            bus_if.imem_rsp_data  = memf(pq[0].addr);
        end else begin
            bus_if.imem_rsp_valid = 1'b0;
            bus_if.imem_rsp_data  = $urandom;
        end
        #1;
        stale_n = 0;
        foreach (pq[i]) if (pq[i].stale) stale_n++;
        held   = issued - delivered + stale_n;
        exp_rv = !bus_if.redirect && (held < QDEPTH);
        exp_iv = (fresh_arr - delivered) > 0;
        check("req_valid",   32'(bus_if.imem_req_valid), 32'(exp_rv));
        check("req_addr",    bus_if.imem_req_addr, exp_req_addr);
        check("instr_valid", 32'(bus_if.instr_valid), 32'(exp_iv));
        if (exp_iv) begin
            check("pc_plus_4", bus_if.pc_plus_4, exp_deliv + 32'd4);
            check("instr",     bus_if.instr, memf(exp_deliv));
        end
        if (bus_if.redirect) begin
            if (bus_if.imem_rsp_valid) void'(pq.pop_front());
            foreach (pq[i]) pq[i].stale = 1'b1;
            exp_req_addr = bus_if.redirect_pc & 32'hFFFF_FFFC;
            exp_deliv    = exp_req_addr;
            issued       = 0;
            delivered    = 0;
            fresh_arr    = 0;
        end else begin
            if (exp_rv && bus_if.imem_req_ready) begin
                due = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                e.due   = due;
                e.addr  = exp_req_addr;
                e.stale = 1'b0;
                pq.push_back(e);
                exp_req_addr += 32'd4;
                issued++;
            end
            if (bus_if.imem_rsp_valid) begin
                e = pq.pop_front();
                if (!e.stale) fresh_arr++;
            end
            if (exp_iv && bus_if.id_ready) begin
                delivered++;
                exp_deliv += 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0);
    endtask

    task automatic set_mode(input int idr, input int rdy, input int redir, input int lo, input int hi);
        p_idr = idr; p_rdy = rdy; p_redir = redir; lat_lo = lo; lat_hi = hi;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b0;
        drive_idle();
        model_reset();
        set_mode(100, 100, 0, 1, 1);

        // Held in reset for three cycles
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset_vals();
        end
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Streaming with single-cycle memory
        run(20);
        // Stall fill then drain
        set_mode(0, 100, 0, 1, 1);
        run(12);
        set_mode(100, 100, 0, 1, 1);
        run(12);
        // Redirect with in-flight fetches at 3-cycle latency
        set_mode(100, 100, 0, 3, 3);
        run(5);
        cycle(1'b1, 32'h0000_0100);
        run(15);
        // Misaligned redirect across the address wrap
        set_mode(100, 100, 0, 1, 2);
        cycle(1'b1, 32'hFFFF_FFFE);
        run(10);

        // Randomized traffic across varied modes
        for (int m = 0; m < 15; m++) begin
            set_mode(int'($urandom_range(100)), int'($urandom_range(100, 20)),
                     int'($urandom_range(15)), 1, int'($urandom_range(5, 1)));
            run(200);
        end

        // Reset mid-operation after filling the queue
        set_mode(0, 100, 0, 2, 3);
        run(10);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        repeat (2) begin
            @(negedge clk);
            drive_idle();
            #1;
            check_reset_vals();
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        last_due = cyc;
        set_mode(100, 100, 0, 1, 1);
        run(20);

        for (int m = 0; m < 5; m++) begin
            set_mode(int'($urandom_range(100)), int'($urandom_range(100, 20)),
                     int'($urandom_range(20)), 1, int'($urandom_range(4, 1)));
            run(200);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
